// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fetch_pkg
//  Description : Constants shared by the instruction fetcher and the 9-bit
//                core. These are the fetcher state encodings, the opcode field
//                values (bits [8:6] of an IIIXXXYYY word) and the halt word.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int STATE_W = 4;

    localparam logic [3:0] S_IDLE = 4'd0;   // parked, waiting for Start
    localparam logic [3:0] S_FI   = 4'd1;   // ROM latency for instruction word
    localparam logic [3:0] S_LI   = 4'd2;   // latch instruction word
    localparam logic [3:0] S_FM   = 4'd3;   // ROM latency for immediate word
    localparam logic [3:0] S_LM   = 4'd4;   // latch immediate word
    localparam logic [3:0] S_ISS  = 4'd5;   // present instruction, Run strobe
    localparam logic [3:0] S_IMM  = 4'd6;   // present immediate
    localparam logic [3:0] S_WAIT = 4'd7;   // wait for core Done
    localparam logic [3:0] S_HALT = 4'd8;   // stopped on halt word

    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_MVI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;

    localparam logic [8:0] HALT_WORD = 9'h1FF;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Interface   : instr_fetch_if
//  Description : Bus bundle between the fetcher, the instruction ROM and the
//                core.
//                  ADDR  - ROM read address (data returns one cycle later)
//                  ROM_Q - ROM read data
//                  DIN   - word presented to the core
//                  Run   - one-cycle strobe, DIN holds an instruction
//                  Done  - core completion
//                master: the fetcher. slave: the ROM/core side.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9
);
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] ROM_Q;
    logic [DATA_W-1:0] DIN;
    logic              Run;
    logic              Done;

    modport master (output ADDR, output DIN, output Run, input ROM_Q, input Done);
    modport slave  (input ADDR, input DIN, input Run, output ROM_Q, output Done);
endinterface
`default_nettype wire

// File: rtl/instr_fetch_pc.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc
//  Description : Program counter. It is an ADDR_W-bit up-counter that wraps
//                from 2**ADDR_W-1 to 0.
//                  Clock  - rising-edge clock
//                  Resetn - asynchronous active-low clear
//                  inc    - synchronous increment enable
//                  count  - current counter value
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_pc #(
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              inc,
    output logic [ADDR_W-1:0] count
);

    logic [ADDR_W-1:0] r_count;

    // Wrap-around comes free from the fixed-width add.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Feeds the 9-bit core. The block steps a PC through a
//                synchronous-read ROM and presents each instruction on DIN
//                with a one-cycle Run strobe. For mvi, the block presents the
//                immediate word on the following cycle. After each
//                instruction, the block waits for the core Done.
//                Ports:
//                  Clock  - rising-edge clock
//                  Resetn - asynchronous active-low reset
//                  Start  - level: run program / stop after current instr
//                  bus    - instr_fetch_if.master (ADDR, ROM_Q, DIN, Run, Done)
//                  Busy   - high outside S_IDLE (and S_HALT)
//                  PC     - address of the next instruction to fetch
//                Configuration macro:
//                  FETCH_HALT_EN - the ROM word 9'h1FF parks the fetcher in
//                                  S_HALT. Only Resetn releases it.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int         ADDR_W  = 5,
    parameter int         DATA_W  = 9,
    parameter logic [2:0] MVI_OPC = OPC_MVI
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    instr_fetch_if.master     bus,
    output logic              Busy,
    output logic [ADDR_W-1:0] PC
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [DATA_W-1:0]  r_instr;
    logic [DATA_W-1:0]  r_imm;
    logic [DATA_W-1:0]  r_last;     // last word actually driven to the core
    logic [ADDR_W-1:0]  w_pc;
    logic               w_inc;
    logic               w_rom_mvi;
    logic               w_instr_mvi;
    logic               w_rom_halt;

    assign w_rom_mvi   = (bus.ROM_Q[DATA_W-1 -: 3] == MVI_OPC);
    assign w_instr_mvi = (r_instr[DATA_W-1 -: 3] == MVI_OPC);

`ifdef FETCH_HALT_EN
    assign w_rom_halt = (bus.ROM_Q == DATA_W'(HALT_WORD));
`else
    assign w_rom_halt = 1'b0;
`endif

    // PC advances once for the instruction word and once for the immediate.
    // A halt word leaves the PC pointing at the halt word.
    assign w_inc = ((r_state == S_LI) && !w_rom_halt) || (r_state == S_LM);

    fetch_pc #(.ADDR_W(ADDR_W)) u_pc (
        .Clock  (Clock),
        .Resetn (Resetn),
        .inc    (w_inc),
        .count  (w_pc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (Start) w_next = S_FI;
            S_FI:   w_next = S_LI;
            S_LI: begin
                if (w_rom_halt)     w_next = S_HALT;
                else if (w_rom_mvi) w_next = S_FM;
                else                w_next = S_ISS;
            end
            S_FM:   w_next = S_LM;
            S_LM:   w_next = S_ISS;
            S_ISS:  w_next = w_instr_mvi ? S_IMM : S_WAIT;
            S_IMM:  w_next = S_WAIT;
            // Done is only looked at here. A Done in any other state,
            // including the Run cycle, is dropped.
            S_WAIT: if (bus.Done) w_next = Start ? S_FI : S_IDLE;
`ifdef FETCH_HALT_EN
            S_HALT: w_next = S_HALT;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_imm   <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_LI)  r_instr <= bus.ROM_Q;
            if (r_state == S_LM)  r_imm   <= bus.ROM_Q;
            if (r_state == S_ISS) r_last  <= r_instr;
            if (r_state == S_IMM) r_last  <= r_imm;
        end
    end

    // The PC has not yet advanced in S_LI. An mvi needs its immediate address
    // on the bus now, so the ROM data arrives for S_FM/S_LM.
    assign bus.ADDR = ((r_state == S_LI) && w_rom_mvi) ? (w_pc + 1'b1) : w_pc;

    assign bus.DIN  = (r_state == S_ISS) ? r_instr :
                      (r_state == S_IMM) ? r_imm   : r_last;
    assign bus.Run  = (r_state == S_ISS);
    assign Busy     = (r_state != S_IDLE) && (r_state != S_HALT);
    assign PC       = w_pc;

endmodule
`default_nettype wire
